// File: rtl/upower_trace_buffer.sv
// rtl/upower_trace_buffer.sv - retire-trace FIFO capturing core writebacks for host readout
module upower_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int PC_WIDTH   = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     clear,
    input  logic                     wb_valid,
    input  logic [PC_WIDTH-1:0]      wb_pc,
    input  logic [4:0]               wb_rt,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [PC_WIDTH-1:0]      rd_pc,
    output logic [4:0]               rd_rt,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   L_FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] L_ONE_PTR  = AW'(1);

    logic [PC_WIDTH-1:0]   r_mem_pc   [DEPTH];
    logic [4:0]            r_mem_rt   [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [15:0]   r_drop_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_flush;

    // Fullness comes from the registered count only: a same-cycle pop never frees a slot.
    assign w_full  = (r_count == L_FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = arm && wb_valid && !w_full;
    assign w_drop  = arm && wb_valid && w_full;
    assign w_pop   = !w_empty && rd_ready;
    assign w_flush = reset || clear;

    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + L_ONE_PTR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + L_ONE_PTR;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + L_ONE_CNT;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - L_ONE_CNT;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
        end
    end

    // Storage has no reset; stale entries are unreachable once pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (w_push && !w_flush) begin
            r_mem_pc[r_wr_ptr]   <= wb_pc;
            r_mem_rt[r_wr_ptr]   <= wb_rt;
            r_mem_data[r_wr_ptr] <= wb_data;
        end
    end

    assign rd_valid   = !w_empty;
    assign rd_pc      = w_empty ? '0 : r_mem_pc[r_rd_ptr];
    assign rd_rt      = w_empty ? '0 : r_mem_rt[r_rd_ptr];
    assign rd_data    = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_upower_trace_buffer.sv
// tb/tb_upower_trace_buffer.sv - directed self-checking bench for upower_trace_buffer
module tb_upower_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        arm;
    logic        clear;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [4:0]  wb_rt;
    logic [63:0] wb_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_pc;
    logic [4:0]  rd_rt;
    logic [63:0] rd_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;

    int n_total = 0;
    int n_bad   = 0;

    upower_trace_buffer #(.DEPTH(16), .PC_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .arm        (arm),
        .clear      (clear),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .wb_rt      (wb_rt),
        .wb_data    (wb_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_pc      (rd_pc),
        .rd_rt      (rd_rt),
        .rd_data    (rd_data),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic commit(input logic [63:0] pc, input logic [4:0] rt, input logic [63:0] data);
        wb_valid = 1'b1;
        wb_pc    = pc;
        wb_rt    = rt;
        wb_data  = data;
        step();
        wb_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; clear = 1'b0; wb_valid = 1'b0;
        wb_pc = '0; wb_rt = '0; wb_data = '0; rd_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_pc", rd_pc, 64'd0);
        check("rst_rt", 64'(rd_rt), 64'd0);
        check("rst_data", rd_data, 64'd0);

        // single commit
        arm = 1'b1;
        commit(64'h100, 5'd3, 64'h2A);
        check("one_valid", 64'(rd_valid), 64'd1);
        check("one_pc", rd_pc, 64'h100);
        check("one_rt", 64'(rd_rt), 64'd3);
        check("one_data", rd_data, 64'h2A);
        check("one_count", 64'(count), 64'd1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("one_pop_valid", 64'(rd_valid), 64'd0);
        check("one_pop_count", 64'(count), 64'd0);
        check("one_pop_data", rd_data, 64'd0);

        // fill and overflow
        for (int i = 0; i < 20; i++) begin
            commit(64'h1000 + 64'(4 * i), 5'(i), 64'(i));
        end
        check("fill_count", 64'(count), 64'd16);
        check("fill_ovf", 64'(overflow), 64'd1);
        check("fill_drop", 64'(drop_count), 64'd4);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", 64'(rd_valid), 64'd1);
            check("drain_data", rd_data, 64'(i));
            check("drain_pc", rd_pc, 64'h1000 + 64'(4 * i));
            step();
        end
        rd_ready = 1'b0;
        check("drain_empty", 64'(rd_valid), 64'd0);
        check("drain_count", 64'(count), 64'd0);
        check("drain_ovf_sticky", 64'(overflow), 64'd1);

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr1_ovf", 64'(overflow), 64'd0);
        check("clr1_drop", 64'(drop_count), 64'd0);

        // streaming across pointer wrap
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            commit(64'h2000 + 64'(i), 5'(i), 64'd100 + 64'(i));
            check("stream_valid", 64'(rd_valid), 64'd1);
            check("stream_data", rd_data, 64'd100 + 64'(i));
            check("stream_count", 64'(count), 64'd1);
        end
        step();
        rd_ready = 1'b0;
        check("stream_end_count", 64'(count), 64'd0);
        check("stream_ovf", 64'(overflow), 64'd0);

        // simultaneous push and pop at full
        for (int i = 0; i < 16; i++) begin
            commit(64'h3000, 5'd7, 64'd200 + 64'(i));
        end
        check("full_count", 64'(count), 64'd16);
        rd_ready = 1'b1;
        commit(64'h3FFF, 5'd9, 64'd999);
        rd_ready = 1'b0;
        check("pp_count", 64'(count), 64'd15);
        check("pp_drop", 64'(drop_count), 64'd1);
        check("pp_ovf", 64'(overflow), 64'd1);
        check("pp_head", rd_data, 64'd201);
        rd_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("pp_drain", rd_data, 64'd200 + 64'(i));
            step();
        end
        rd_ready = 1'b0;
        check("pp_no_dropped", 64'(rd_valid), 64'd0);

        // clear with entries held and a same-cycle commit
        for (int i = 0; i < 5; i++) begin
            commit(64'h4000, 5'd1, 64'd50 + 64'(i));
        end
        check("pre_clr_count", 64'(count), 64'd5);
        clear = 1'b1;
        commit(64'h4444, 5'd2, 64'd77);
        clear = 1'b0;
        check("clr_count", 64'(count), 64'd0);
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_drop", 64'(drop_count), 64'd0);
        check("clr_valid", 64'(rd_valid), 64'd0);

        // disarmed commits are ignored
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            commit(64'h5000, 5'd4, 64'd60 + 64'(i));
        end
        check("disarm_count", 64'(count), 64'd0);
        check("disarm_drop", 64'(drop_count), 64'd0);

        // capture resumes after clear
        arm = 1'b1;
        commit(64'h6000, 5'd31, 64'hDEAD);
        check("post_clr_data", rd_data, 64'hDEAD);
        check("post_clr_rt", 64'(rd_rt), 64'd31);
        check("post_clr_count", 64'(count), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/upower_trace_buffer.md
# uPower_trace_buffer

Hardware retire-trace recorder for the uPOWER core. It captures every register writeback the core commits (PC, destination register, data) into a first-word-fall-through FIFO. The buffer drains to a host or bench reader over a valid/ready handshake. It sits beside `uPower_core` on the same clock, observing the writeback stage so that results can be read out of hardware instead of inspected in waveforms.

## Interface
Parameters:
- `DEPTH`, 16: number of trace entries; power of two, at least 2.
- `PC_WIDTH`, 64: width of captured PC.
- `DATA_WIDTH`, 64: width of captured writeback data.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `arm`  in  1  level; capture is enabled while high.
- `clear`  in  1  synchronous flush of buffer and statistics.
- `wb_valid`  in  1  core commits a register write this cycle.
- `wb_pc`  in  PC_WIDTH  PC of the committing instruction.
- `wb_rt`  in  5  destination GPR index.
- `wb_data`  in  DATA_WIDTH  value written.
- `rd_valid`  out  1  head entry available.
- `rd_ready`  in  1  reader accepts the head entry.
- `rd_pc`  out  PC_WIDTH  head entry PC.
- `rd_rt`  out  5  head entry GPR index.
- `rd_data`  out  DATA_WIDTH  head entry data.
- `count`  out  log2(DEPTH)+1  entries currently held.
- `overflow`  out  1  sticky; at least one commit was dropped.
- `drop_count`  out  16  dropped commits, saturating.

## Operation
- Storage: DEPTH entries of {pc, rt, data}. Write pointer and read pointer are each log2(DEPTH) bits and wrap modulo DEPTH. `count` is a separate counter holding 0..DEPTH.
- Push: occurs when `arm && wb_valid && count != DEPTH`. The entry is written at the write pointer, and the write pointer increments.
- Drop: occurs when `arm && wb_valid && count == DEPTH`. Storage is not modified. `overflow` is set to 1. `drop_count` increments unless it is already 16'hFFFF.
- Full is evaluated on the registered `count` from the start of the cycle. A pop in the same cycle does not make room, so a push when full is still a drop.
- Pop: occurs when `rd_valid && rd_ready`. The read pointer increments. When `rd_valid` is 0, `rd_ready` is ignored.
- Push and pop in the same cycle (not full, not empty): both happen, and `count` is unchanged.
- `rd_valid = (count != 0)`. `rd_pc`, `rd_rt` and `rd_data` show the entry at the read pointer and are forced to all-zero when `rd_valid` is 0.
- `wb_valid` while `arm` is 0: ignored. It is neither stored nor counted.
- `clear`: pointers, `count`, `overflow` and `drop_count` all go to 0. It overrides any push, drop or pop in the same cycle. Storage contents need not be zeroed.
- `reset`: same effect as `clear`, and has priority over every other input.

## Timing
- All outputs are registered or derived from registered state only. There is no combinational path from `wb_*` to `rd_*`.
- Reset values: `rd_valid` 0, `rd_pc`/`rd_rt`/`rd_data` 0, `count` 0, `overflow` 0, `drop_count` 0.
- Capture latency: a commit pushed at edge N into an empty buffer gives `rd_valid`=1 with its fields from edge N onward, i.e. in cycle N+1.
- Pop takes effect at the edge where `rd_valid && rd_ready`. The next entry, or `rd_valid`=0, appears immediately after that edge.
- Throughput: one push and one pop per cycle, sustained.
- `overflow` and `drop_count` update at the same edge as the dropping commit.
- Reset or clear asserted mid-drain: the buffer is empty on the following cycle, and later commits start at pointer 0.

## Test plan
- Reset, then check the idle state: `rd_valid`=0, `count`=0, `overflow`=0, `drop_count`=0, all `rd_*`=0.
- Single commit: arm=1, one pulse of wb_valid with pc=0x100, rt=3, data=0x2A. Required: the next cycle shows `rd_valid`=1 with those fields and `count`=1. Pulse `rd_ready` for one cycle -> `rd_valid`=0 and `count`=0.
- Fill and overflow: DEPTH=16, rd_ready=0, 20 consecutive commits with data=0..19. Required: `count`=16, `overflow`=1, `drop_count`=4. A drain returns data 0..15 in order, with no entry from 16..19.
- Streaming with wrap: rd_ready=1 held high, 40 consecutive commits. Required: every entry is read in order across pointer wrap-around, `count` never exceeds 1, and `overflow` stays 0.
- Simultaneous push and pop at full: buffer full, rd_ready=1 and wb_valid=1 in the same cycle. Required: the head is popped, the commit is dropped, `count` becomes 15, and `drop_count` increments by 1.
- Clear and disarm: `clear` with 5 entries held and a commit in the same cycle -> `count`=0, `overflow`=0, `drop_count`=0. With arm=0, 3 commits -> `count` stays 0 and `drop_count` stays 0.
